// File: rtl/signed_mul16_pipe.sv
// 16x16 signed multiplier: radix-4 Booth partial products, CSA tree, final adder.
// Three register stages (PPs, sum/carry, product); one operation accepted every cycle.
module signed_mul16_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] X,
   input  logic [15:0] Y,
   output logic        out_valid,
   output logic [31:0] R
);

   // 3:2 compressor on full words; returns {carry, sum}, carry already shifted up
   function automatic logic [63:0] csa(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
      logic [31:0] s, k;
      s = a ^ b ^ c;
      k = ((a & b) | (a & c) | (b & c)) << 1;
      return {k, s};
   endfunction

   logic [18:0] yx;
   logic [16:0] x1, x2;
   logic [31:0] pp_d [9];
   logic [31:0] corr_d;
   logic [31:0] pp_q [9];
   logic [31:0] corr_q;
   logic [31:0] s [8];
   logic [31:0] c [8];
   logic [31:0] sum_q, carry_q;
   logic [2:0]  vld_pipe;

   // Two copies of the sign bit above Y make the ninth digit always zero
   assign yx = {Y[15], Y[15], Y, 1'b0};
   assign x1 = {X[15], X};
   assign x2 = {X, 1'b0};

   always_comb begin
      logic [2:0]  b;
      logic [16:0] mag, sel;
      logic        neg;
      corr_d = '0;
      for (int i = 0; i < 9; i++) begin
         b = yx[2*i +: 3];
         case (b)
            3'b001, 3'b010, 3'b101, 3'b110: mag = x1;
            3'b011, 3'b100:                 mag = x2;
            default:                        mag = '0;
         endcase
         neg = b[2] & ~(b[1] & b[0]);
         // Negation = one's complement here, +1 carried in corr at the digit's weight
         sel = neg ? ~mag : mag;
         pp_d[i] = {{15{sel[16]}}, sel} << (2*i);
         corr_d[2*i] = neg;
      end
   end

   always_comb begin
      {c[0], s[0]} = csa(pp_q[0], pp_q[1], pp_q[2]);
      {c[1], s[1]} = csa(pp_q[3], pp_q[4], pp_q[5]);
      {c[2], s[2]} = csa(pp_q[6], pp_q[7], pp_q[8]);
      {c[3], s[3]} = csa(s[0], c[0], s[1]);
      {c[4], s[4]} = csa(c[1], s[2], c[2]);
      {c[5], s[5]} = csa(s[3], c[3], s[4]);
      {c[6], s[6]} = csa(s[5], c[5], c[4]);
      {c[7], s[7]} = csa(s[6], c[6], corr_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 9; i++) pp_q[i] <= '0;
         corr_q   <= '0;
         sum_q    <= '0;
         carry_q  <= '0;
         R        <= '0;
         vld_pipe <= '0;
      end else begin
         for (int i = 0; i < 9; i++) pp_q[i] <= pp_d[i];
         corr_q   <= corr_d;
         sum_q    <= s[7];
         carry_q  <= c[7];
         R        <= sum_q + carry_q;
         vld_pipe <= {vld_pipe[1:0], in_valid};
      end
   end

   assign out_valid = vld_pipe[2];

endmodule

// File: tb/tb_signed_mul16_pipe.sv
// Directed and random checks of signed_mul16_pipe against hand-computed products.
module tb_signed_mul16_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] X, Y;
   logic        out_valid;
   logic [31:0] R;

   int errors = 0;
   int checks = 0;

   signed_mul16_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .X(X), .Y(Y),
      .out_valid(out_valid), .R(R)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Issue one op alone, then look at it three cycles later
   task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input int exp);
      in_valid = 1'b1; X = a; Y = b;
      tick(); in_valid = 1'b0;
      tick();
      tick();
      chk({tag, "_v"}, {31'd0, out_valid}, 32'd1);
      chk(tag, R, exp);
   endtask

   logic        pv [3];
   logic [31:0] pr [3];
   logic signed [15:0] ra, rb;

   initial begin
      rst = 1'b1; in_valid = 1'b1; X = 16'd5; Y = 16'd7;
      // reset held two cycles with a valid op on the inputs
      tick();
      chk("rst1_v", {31'd0, out_valid}, 32'd0);
      chk("rst1_r", R, 32'd0);
      tick();
      chk("rst2_v", {31'd0, out_valid}, 32'd0);
      chk("rst2_r", R, 32'd0);
      rst = 1'b0;
      tick();
      chk("rst3_v", {31'd0, out_valid}, 32'd0);
      chk("rst3_r", R, 32'd0);
      tick();
      chk("rst4_v", {31'd0, out_valid}, 32'd0);
      tick();
      chk("first_v", {31'd0, out_valid}, 32'd1);
      chk("first_r", R, 32'd35);

      // back-to-back issue
      in_valid = 1'b1; X = 16'd3; Y = 16'd4;
      tick(); X = -16'sd3;
      tick(); Y = -16'sd4;
      tick(); in_valid = 1'b0;
      chk("pipe0_v", {31'd0, out_valid}, 32'd1);
      chk("pipe0_r", R, 32'd12);
      tick();
      chk("pipe1_v", {31'd0, out_valid}, 32'd1);
      chk("pipe1_r", R, -32'sd12);
      tick();
      chk("pipe2_v", {31'd0, out_valid}, 32'd1);
      chk("pipe2_r", R, 32'd12);
      tick();
      chk("pipe3_v", {31'd0, out_valid}, 32'd0);

      // extremes
      op("mn_mn", 16'h8000, 16'h8000, 1073741824);
      op("mn_mx", 16'h8000, 16'h7FFF, -1073709056);
      op("mx_mx", 16'h7FFF, 16'h7FFF, 1073676289);
      op("m1_m1", 16'hFFFF, 16'hFFFF, 1);
      op("z_mn",  16'h0000, 16'h8000, 0);
      op("m1_y",  16'hFFFF, 16'd12345, -12345);
      op("mx_z",  16'h7FFF, 16'h0000, 0);

      // Booth digit patterns
      op("b_aaaa", 16'h1234, 16'hAAAA, -101802360);
      op("b_5555", 16'h1234, 16'h5555, 101797700);
      op("b_ffff", 16'h1234, 16'hFFFF, -4660);
      op("b_8001", 16'h1234, 16'h8001, -152694220);
      op("b_rev",  16'h8001, 16'h1234, -152694220);

      // random stream against a 3-deep expected-value pipeline
      for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pr[i] = '0; end
      tick(); tick(); tick();
      for (int n = 0; n < 250; n++) begin
         chk("rnd_v", {31'd0, out_valid}, {31'd0, pv[2]});
         if (pv[2]) chk("rnd_r", R, pr[2]);
         ra = 16'($urandom); rb = 16'($urandom);
         if (n % 50 == 7) ra = 16'h8000;
         if (n % 50 == 9) rb = 16'hFFFF;
         in_valid = 1'($urandom_range(0, 1)); X = ra; Y = rb;
         pv[2] = pv[1]; pr[2] = pr[1];
         pv[1] = pv[0]; pr[1] = pr[0];
         pv[0] = in_valid; pr[0] = 32'(int'(ra) * int'(rb));
         tick();
      end

      // mid-stream reset: two ops in the pipe, a third on the inputs
      in_valid = 1'b1; X = 16'd100; Y = 16'd200;
      tick(); X = 16'd7;
      tick(); X = 16'd9; rst = 1'b1;
      tick(); rst = 1'b0; in_valid = 1'b0;
      chk("mrst0_v", {31'd0, out_valid}, 32'd0);
      chk("mrst0_r", R, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("mrst%0d_v", i), {31'd0, out_valid}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
